decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage for the RV32IM core: decodes each fetched instruction at enqueue and buffers the decoded `instructions` records in a DEPTH-entry FIFO. It sits between fetch and register-read/execute. Valid/ready handshakes on both sides replace the old `enabled`/`completed` pulse pair, and a flush input discards wrong-path instructions. Decode is corrected over the previous stage: M ops are gated by funct7, all load/store widths are flagged, and unused register fields are zeroed.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ENABLE_M, 1, 1 decodes RV32M; 0 makes funct7=0000001 OP encodings illegal
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept this cycle
- in_pc  in  32  pc of offered instruction
- in_instr  in  32  raw instruction word
- flush  in  1  discard all entries and the current offer
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes head this cycle
- out_instr  out  `instructions`  decoded head record
- out_rs1  out  5  head rs1; 0 if unused or queue empty
- out_rs2  out  5  head rs2; 0 if unused or queue empty
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Enqueue fires when in_valid && in_ready; dequeue fires when out_valid && out_ready.
- in_ready = !flush && (count < DEPTH || out_ready). This is a combinational path from out_ready; full + dequeue + enqueue in one cycle is legal and keeps count at DEPTH.
- Decode runs combinationally on in_instr/in_pc. The record is written into the tail entry at the enqueue edge.
- Field rules:
  - rd is valid for R/I/U/J types, else 0.
  - rs1 is valid for R/I/S/B types and register-form CSR ops, else 0.
  - rs2 is valid for R/S/B types, else 0.
- Immediate rules: sign-extended I/S/B/J, U = {instr[31:12],12'b0}, 0 otherwise.
- OP (0110011) decode:
  - funct7=0000000 selects the base ALU ops.
  - funct7=0100000 selects sub/sra.
  - funct7=0000001 selects mul..remu, only when ENABLE_M=1.
- OP-IMM shifts require funct7 = 0000000 (slli/srli) or 0100000 (srai).
- fence requires funct3=000. fence.i, ecall, ebreak and mret require exact instr[31:7] matches.
- Flags:
  - is_load = lb|lh|lw|lbu|lhu.
  - is_store = sb|sh|sw.
  - is_conditional_jump = any branch.
  - is_illegal_instr = no recognised op; such entries are enqueued normally.
- Flush: count, head and tail pointers go to 0 at the edge. An enqueue in the same cycle is blocked (in_ready=0). A dequeue handshake in the same cycle is still taken by the consumer, and the head is discarded anyway.
- Empty queue: out_valid=0, out_instr all-zero, out_rs1=out_rs2=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.

## Timing
- Latency: enqueue at edge N → out_valid=1 with that record after edge N. There is no same-cycle bypass from in to out.
- Throughput: one enqueue and one dequeue per cycle sustained.
- out_* depend only on registered state, except in_ready as stated above.
- Reset values: count=0, out_valid=0, out_instr='0, out_rs1=0, out_rs2=0, pointers 0.
- in_ready during reset cycle is "don't care". It reads 1 from the first cycle after rst deassertion.
- Reset mid-operation drops all entries, same as flush.

## Structure
- `instructions` struct and opcode/funct constants live in def.sv. Add OP_* opcode and F7_* funct7 localparams there; no new struct fields.
- Sub-module `instr_decoder`: purely combinational, takes (instr_raw, pc), returns an `instructions` record. It has parameter ENABLE_M.
- decode_queue holds the storage array of `instructions`, the pointers, the count and the handshake logic.

## Test plan
- addi x1,x0,5 (0x00500093, pc 0x100) → next cycle out_valid=1, addi=1, rd=1, rs1=0, rs2=0, imm=5, pc=0x100, count=1.
- beq x1,x2,-8 (0xFE208CE3) → beq=1, is_conditional_jump=1, rd=0, out_rs1=1, out_rs2=2, imm=0xFFFFFFF8.
- mul x3,x1,x2 (0x022081B3): with ENABLE_M=1 → mul=1, add=0, illegal=0. With ENABLE_M=0 → all ops 0, is_illegal_instr=1.
- Fill and drain:
  - out_ready=0, push DEPTH words → in_ready=0, count=DEPTH.
  - Then hold in_valid=1 and out_ready=1 → in_ready=1, count stays DEPTH, FIFO order preserved across pointer wrap.
- Flush with 3 entries while in_valid=1 → in_ready=0 that cycle, next cycle count=0, out_valid=0, out_instr='0.
- lh x5,-4(x2) (0xFFC11283) → lh=1, is_load=1, imm=0xFFFFFFFC. sh x5,8(x2) (0x00511423) → sh=1, is_store=1, rd=0, imm=8.

Source files
------------

// File: rtl/def.sv
// Shared decode definitions: RV32 opcode/funct7 constants and the decoded
// `instructions` record carried through the decode queue.
package def;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu;
        logic sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_r, srl, sra, or_r, and_r;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic fence, fence_i, ecall, ebreak, mret;
        logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
        logic is_load, is_store, is_conditional_jump, is_illegal_instr;
    } instructions;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I(M) decoder: raw instruction word + pc in, one
// `instructions` record out with unused register fields forced to zero.
module instr_decoder
    import def::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr_raw,
    input  logic [31:0] pc,
    output instructions decoded
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    instructions ops;
    logic r_t, i_t, s_t, b_t, u_t, j_t, csr_t, csr_reg, sys_t;

    assign opcode = instr_raw[6:0];
    assign funct3 = instr_raw[14:12];
    assign funct7 = instr_raw[31:25];
    assign imm_i  = {{20{instr_raw[31]}}, instr_raw[31:20]};
    assign imm_s  = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
    assign imm_b  = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7], instr_raw[30:25], instr_raw[11:8], 1'b0};
    assign imm_u  = {instr_raw[31:12], 12'b0};
    assign imm_j  = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12], instr_raw[20], instr_raw[30:21], 1'b0};

    always_comb begin
        ops = '0;
        case (opcode)
            OP_LUI:    ops.lui   = 1'b1;
            OP_AUIPC:  ops.auipc = 1'b1;
            OP_JAL:    ops.jal   = 1'b1;
            OP_JALR:   ops.jalr  = (funct3 == 3'b000);
            OP_BRANCH: case (funct3)
                3'b000:  ops.beq  = 1'b1;
                3'b001:  ops.bne  = 1'b1;
                3'b100:  ops.blt  = 1'b1;
                3'b101:  ops.bge  = 1'b1;
                3'b110:  ops.bltu = 1'b1;
                3'b111:  ops.bgeu = 1'b1;
                default: ;
            endcase
            OP_LOAD: case (funct3)
                3'b000:  ops.lb  = 1'b1;
                3'b001:  ops.lh  = 1'b1;
                3'b010:  ops.lw  = 1'b1;
                3'b100:  ops.lbu = 1'b1;
                3'b101:  ops.lhu = 1'b1;
                default: ;
            endcase
            OP_STORE: case (funct3)
                3'b000:  ops.sb = 1'b1;
                3'b001:  ops.sh = 1'b1;
                3'b010:  ops.sw = 1'b1;
                default: ;
            endcase
            OP_IMM: case (funct3)
                3'b000: ops.addi  = 1'b1;
                3'b010: ops.slti  = 1'b1;
                3'b011: ops.sltiu = 1'b1;
                3'b100: ops.xori  = 1'b1;
                3'b110: ops.ori   = 1'b1;
                3'b111: ops.andi  = 1'b1;
                3'b001: ops.slli  = (funct7 == F7_BASE);
                3'b101: begin
                    ops.srli = (funct7 == F7_BASE);
                    ops.srai = (funct7 == F7_ALT);
                end
                default: ;
            endcase
            OP_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ops.add   = 1'b1;
                        3'b001:  ops.sll   = 1'b1;
                        3'b010:  ops.slt   = 1'b1;
                        3'b011:  ops.sltu  = 1'b1;
                        3'b100:  ops.xor_r = 1'b1;
                        3'b101:  ops.srl   = 1'b1;
                        3'b110:  ops.or_r  = 1'b1;
                        default: ops.and_r = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    ops.sub = (funct3 == 3'b000);
                    ops.sra = (funct3 == 3'b101);
                end else if (funct7 == F7_MULDIV && ENABLE_M) begin
                    case (funct3)
                        3'b000:  ops.mul    = 1'b1;
                        3'b001:  ops.mulh   = 1'b1;
                        3'b010:  ops.mulhsu = 1'b1;
                        3'b011:  ops.mulhu  = 1'b1;
                        3'b100:  ops.div    = 1'b1;
                        3'b101:  ops.divu   = 1'b1;
                        3'b110:  ops.rem    = 1'b1;
                        default: ops.remu   = 1'b1;
                    endcase
                end
            end
            OP_MISC_MEM: begin
                ops.fence   = (funct3 == 3'b000);
                ops.fence_i = (instr_raw[31:7] == 25'h0000020);
            end
            OP_SYSTEM: begin
                ops.ecall  = (instr_raw[31:7] == 25'h0000000);
                ops.ebreak = (instr_raw[31:7] == 25'h0002000);
                ops.mret   = (instr_raw[31:7] == 25'h0604000);
                case (funct3)
                    3'b001:  ops.csrrw  = 1'b1;
                    3'b010:  ops.csrrs  = 1'b1;
                    3'b011:  ops.csrrc  = 1'b1;
                    3'b101:  ops.csrrwi = 1'b1;
                    3'b110:  ops.csrrsi = 1'b1;
                    3'b111:  ops.csrrci = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Format classes are derived from the recognised op, so an illegal word has no fields.
    assign u_t     = ops.lui | ops.auipc;
    assign j_t     = ops.jal;
    assign b_t     = ops.beq | ops.bne | ops.blt | ops.bge | ops.bltu | ops.bgeu;
    assign s_t     = ops.sb | ops.sh | ops.sw;
    assign i_t     = ops.jalr | ops.lb | ops.lh | ops.lw | ops.lbu | ops.lhu
                   | ops.addi | ops.slti | ops.sltiu | ops.xori | ops.ori | ops.andi
                   | ops.slli | ops.srli | ops.srai;
    assign r_t     = ops.add | ops.sub | ops.sll | ops.slt | ops.sltu | ops.xor_r | ops.srl
                   | ops.sra | ops.or_r | ops.and_r | ops.mul | ops.mulh | ops.mulhsu
                   | ops.mulhu | ops.div | ops.divu | ops.rem | ops.remu;
    assign csr_reg = ops.csrrw | ops.csrrs | ops.csrrc;
    assign csr_t   = csr_reg | ops.csrrwi | ops.csrrsi | ops.csrrci;
    assign sys_t   = ops.fence | ops.fence_i | ops.ecall | ops.ebreak | ops.mret;

    always_comb begin
        decoded                     = ops;
        decoded.pc                  = pc;
        decoded.is_load             = ops.lb | ops.lh | ops.lw | ops.lbu | ops.lhu;
        decoded.is_store            = s_t;
        decoded.is_conditional_jump = b_t;
        decoded.is_illegal_instr    = !(u_t | j_t | b_t | s_t | i_t | r_t | csr_t | sys_t);
        decoded.rd  = (r_t | i_t | u_t | j_t | csr_t) ? instr_raw[11:7] : 5'd0;
        decoded.rs1 = (r_t | i_t | s_t | b_t | csr_reg) ? instr_raw[19:15] : 5'd0;
        decoded.rs2 = (r_t | s_t | b_t) ? instr_raw[24:20] : 5'd0;
        if (i_t | csr_t)
            decoded.imm = imm_i;
        else if (s_t)
            decoded.imm = imm_s;
        else if (b_t)
            decoded.imm = imm_b;
        else if (u_t)
            decoded.imm = imm_u;
        else if (j_t)
            decoded.imm = imm_j;
        else
            decoded.imm = 32'd0;
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes each fetched word on enqueue and buffers the records
// in a DEPTH-entry FIFO with valid/ready on both sides and a flush input.
module decode_queue
    import def::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output instructions                  out_instr,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    instructions       mem [DEPTH];
    instructions       dec;
    logic [PW-1:0]     head, tail;
    logic              enq, deq;

    instr_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
        .instr_raw (in_instr),
        .pc        (in_pc),
        .decoded   (dec)
    );

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready  = !flush && (count < FULL || out_ready);
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign out_instr = out_valid ? mem[head] : '0;
    assign out_rs1   = out_instr.rs1;
    assign out_rs2   = out_instr.rs2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            if (enq && !deq)
                count <= count + 1'b1;
            else if (!enq && deq)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !rst)
            mem[tail] <= dec;
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of decode vectors plus fill/drain, flush and
// reset sequences, with a scoreboard checking every dequeued record in order.
module tb_decode_queue;
    import def::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst, in_valid, flush, out_ready;
    logic [31:0]       in_pc, in_instr;
    logic              in_ready, out_valid;
    instructions       out_instr;
    logic [4:0]        out_rs1, out_rs2;
    logic [CW-1:0]     count;
    logic              in_ready_nm, out_valid_nm;
    instructions       out_instr_nm;
    logic [4:0]        out_rs1_nm, out_rs2_nm;
    logic [CW-1:0]     count_nm;

    int errors = 0;
    int checks = 0;
    instructions scoreboard[$];
    instructions cur_exp;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        instructions exp;
    } vec_t;
    vec_t vecs[12];

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .count(count)
    );

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nm),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid_nm), .out_ready(out_ready), .out_instr(out_instr_nm),
        .out_rs1(out_rs1_nm), .out_rs2(out_rs2_nm), .count(count_nm)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_record(input string name, input instructions act, input instructions exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instructions rec(input logic [31:0] pc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
        instructions r;
        r     = '0;
        r.pc  = pc;
        r.rd  = rd;
        r.rs1 = rs1;
        r.rs2 = rs2;
        r.imm = imm;
        return r;
    endfunction

    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc, input instructions exp);
        in_instr = instr;
        in_pc    = pc;
        cur_exp  = exp;
        in_valid = 1'b1;
    endtask

    task automatic apply_addi(input int k, input logic [31:0] pc);
        instructions e;
        logic [31:0] imm;
        imm    = 32'(k);
        e      = rec(pc, 5'd1, 5'd0, 5'd0, imm);
        e.addi = 1'b1;
        apply_stimulus(32'h00000093 | (imm << 20), pc, e);
    endtask

    // Scoreboard: compare on every dequeue handshake, record on every enqueue.
    always @(negedge clk) begin
        if (rst) begin
            scoreboard.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (scoreboard.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got record %h expected no output", out_instr);
                end else begin
                    instructions e;
                    e = scoreboard.pop_front();
                    check_record("sb_head", out_instr, e);
                    check_value("sb_rs1", 32'(out_rs1), 32'(e.rs1));
                    check_value("sb_rs2", 32'(out_rs2), 32'(e.rs2));
                end
            end
            if (flush)
                scoreboard.delete();
            else if (in_valid && in_ready)
                scoreboard.push_back(cur_exp);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h00500093, 32'h100, rec(32'h100, 5'd1, 5'd0, 5'd0, 32'd5)};
        vecs[0].exp.addi = 1'b1;
        vecs[1]  = '{32'hFE208CE3, 32'h104, rec(32'h104, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8)};
        vecs[1].exp.beq = 1'b1;
        vecs[1].exp.is_conditional_jump = 1'b1;
        vecs[2]  = '{32'h022081B3, 32'h108, rec(32'h108, 5'd3, 5'd1, 5'd2, 32'd0)};
        vecs[2].exp.mul = 1'b1;
        vecs[3]  = '{32'hFFC11283, 32'h10C, rec(32'h10C, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC)};
        vecs[3].exp.lh = 1'b1;
        vecs[3].exp.is_load = 1'b1;
        vecs[4]  = '{32'h00511423, 32'h110, rec(32'h110, 5'd0, 5'd2, 5'd5, 32'd8)};
        vecs[4].exp.sh = 1'b1;
        vecs[4].exp.is_store = 1'b1;
        vecs[5]  = '{32'h123453B7, 32'h114, rec(32'h114, 5'd7, 5'd0, 5'd0, 32'h12345000)};
        vecs[5].exp.lui = 1'b1;
        vecs[6]  = '{32'h010000EF, 32'h118, rec(32'h118, 5'd1, 5'd0, 5'd0, 32'd16)};
        vecs[6].exp.jal = 1'b1;
        vecs[7]  = '{32'h4031D213, 32'h11C, rec(32'h11C, 5'd4, 5'd3, 5'd0, 32'h403)};
        vecs[7].exp.srai = 1'b1;
        vecs[8]  = '{32'h407302B3, 32'h120, rec(32'h120, 5'd5, 5'd6, 5'd7, 32'd0)};
        vecs[8].exp.sub = 1'b1;
        vecs[9]  = '{32'h00000073, 32'h124, rec(32'h124, 5'd0, 5'd0, 5'd0, 32'd0)};
        vecs[9].exp.ecall = 1'b1;
        vecs[10] = '{32'hFFFFFFFF, 32'h128, rec(32'h128, 5'd0, 5'd0, 5'd0, 32'd0)};
        vecs[10].exp.is_illegal_instr = 1'b1;
        vecs[11] = '{32'h40109093, 32'h12C, rec(32'h12C, 5'd0, 5'd0, 5'd0, 32'd0)};
        vecs[11].exp.is_illegal_instr = 1'b1;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; cur_exp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_count", 32'(count), 0);
        check_value("rst_out_valid", 32'(out_valid), 0);
        check_record("rst_out_instr", out_instr, '0);
        check_value("rst_rs1", 32'(out_rs1), 0);
        check_value("rst_rs2", 32'(out_rs2), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_value("post_rst_in_ready", 32'(in_ready), 1);

        // Decode table: one entry at a time through an otherwise empty queue.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            apply_stimulus(vecs[i].instr, vecs[i].pc, vecs[i].exp);
            @(negedge clk);
            check_value("no_bypass_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check_value("vec_out_valid", 32'(out_valid), 1);
            check_value("vec_count", 32'(count), 1);
            check_value("vec_rs1", 32'(out_rs1), 32'(vecs[i].exp.rs1));
            check_value("vec_rs2", 32'(out_rs2), 32'(vecs[i].exp.rs2));
            if (i == 2) begin
                check_value("nom_mul", 32'(out_instr_nm.mul), 0);
                check_value("nom_add", 32'(out_instr_nm.add), 0);
                check_value("nom_illegal", 32'(out_instr_nm.is_illegal_instr), 1);
            end
            @(posedge clk); #1 out_ready = 1'b0;
            @(negedge clk);
            check_value("vec_drained", 32'(count), 0);
        end

        // Fill to DEPTH, then stream through a full queue across pointer wrap.
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            apply_addi(k + 1, 32'h200 + 32'(4 * k));
            if (k == DEPTH) begin
                @(negedge clk);
                check_value("full_in_ready", 32'(in_ready), 0);
                check_value("full_count", 32'(count), DEPTH);
                @(posedge clk); #1 out_ready = 1'b1;
            end
            @(negedge clk);
            if (k < DEPTH)
                check_value("fill_count", 32'(count), 32'(k));
            else begin
                check_value("stream_in_ready", 32'(in_ready), 1);
                check_value("stream_count", 32'(count), DEPTH);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int n = 0;
            while (count != '0 && n < 20) begin
                @(posedge clk); #1 n++;
            end
        end
        check_value("drain_count", 32'(count), 0);
        out_ready = 1'b0;

        // Flush with three entries and an offer pending.
        for (int k = 0; k < 3; k++) begin
            apply_addi(20 + k, 32'h300 + 32'(4 * k));
            @(posedge clk); #1;
        end
        apply_addi(30, 32'h340);
        flush = 1'b1;
        @(negedge clk);
        check_value("flush_in_ready", 32'(in_ready), 0);
        check_value("flush_pre_count", 32'(count), 3);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_value("flush_count", 32'(count), 0);
        check_value("flush_out_valid", 32'(out_valid), 0);
        check_record("flush_out_instr", out_instr, '0);
        check_value("flush_rs1", 32'(out_rs1), 0);

        // Flush coinciding with a dequeue, then confirm pointers restart cleanly.
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            apply_addi(40 + k, 32'h400 + 32'(4 * k));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_value("flush_deq_count", 32'(count), 0);
        @(posedge clk); #1;
        apply_addi(50, 32'h500);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check_value("post_flush_count", 32'(count), 0);

        // Reset mid-operation drops everything.
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            apply_addi(60 + k, 32'h600 + 32'(4 * k));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_value("midrst_count", 32'(count), 0);
        check_value("midrst_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_value("midrst_in_ready", 32'(in_ready), 1);

        check_value("sb_leftover", 32'(scoreboard.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
